// File: rtl/dma_line_scheduler.sv
// Sequences line-buffer write commands into the SDRAM DMA: credit-limited issue,
// wrapping addresses inside the allocated region, completion tracking from the DMA status count.
module dma_line_scheduler #(
  parameter int CMD_FIFO_SIZE = 1,
  parameter int ADR_W         = 28
) (
  input  logic             CLK_80,
  input  logic             RESET,
  input  logic             CFG_START,
  input  logic             CFG_STOP,
  input  logic [ADR_W-1:0] CFG_BASE_ADR,
  input  logic [ADR_W-1:0] CFG_BUF_SIZE,
  input  logic [3:0]       CFG_STRIDE,
  input  logic [ADR_W-1:0] CFG_ALLOC_SIZE,
  input  logic [15:0]      CFG_BUF_CNT,
  input  logic [15:0]      DMA_STATUS_CNT,
  output logic             DMA_ON,
  output logic [ADR_W-1:0] DMA_ADR,
  output logic [ADR_W-1:0] DMA_BUF_SIZE,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      ISSUED_CNT,
  output logic [15:0]      COMPLETED_CNT,
  output logic             ERR
);

  localparam logic [3:0] FIFO_CREDITS = 4'(CMD_FIFO_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ISSUE, S_GAP} state_t;

  state_t           state_reg;
  logic [ADR_W-1:0] base_reg;
  logic [ADR_W-1:0] buf_size_reg;
  logic [ADR_W-1:0] alloc_reg;
  logic [ADR_W-1:0] offset_reg;
  logic [ADR_W+3:0] step_reg;
  logic [15:0]      buf_cnt_reg;
  logic [15:0]      baseline_reg;
  logic [3:0]       credits_reg;

  logic [15:0]      comp;
  logic [15:0]      delta;
  logic [15:0]      outstanding;
  logic             comp_overrun;
  logic             issue_go;
  logic             run_end;
  logic [ADR_W+3:0] offset_sum;
  logic [3:0]       credits_next;

  always_comb begin
    // Modulo-2^16 arithmetic keeps a wrapping status counter transparent.
    comp         = DMA_STATUS_CNT - baseline_reg;
    delta        = comp - COMPLETED_CNT;
    outstanding  = ISSUED_CNT - COMPLETED_CNT;
    comp_overrun = (delta > outstanding);
    issue_go     = (state_reg == S_ISSUE) && (credits_reg != 4'd0) &&
                   (ISSUED_CNT < buf_cnt_reg) && !CFG_STOP;
    run_end      = (state_reg != S_IDLE) && (COMPLETED_CNT == ISSUED_CNT) &&
                   ((ISSUED_CNT == buf_cnt_reg) || CFG_STOP);
    offset_sum   = {4'd0, offset_reg} + step_reg;
    // Without an overrun, delta never exceeds the outstanding count, so 4 bits suffice.
    credits_next = comp_overrun ? (FIFO_CREDITS - {3'd0, issue_go})
                                : (credits_reg + delta[3:0] - {3'd0, issue_go});
  end

  always_ff @(posedge CLK_80) begin
    if (RESET) begin
      state_reg     <= S_IDLE;
      base_reg      <= '0;
      buf_size_reg  <= '0;
      alloc_reg     <= '0;
      offset_reg    <= '0;
      step_reg      <= '0;
      buf_cnt_reg   <= '0;
      baseline_reg  <= '0;
      credits_reg   <= FIFO_CREDITS;
      DMA_ON        <= 1'b0;
      DMA_ADR       <= '0;
      DMA_BUF_SIZE  <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ISSUED_CNT    <= '0;
      COMPLETED_CNT <= '0;
      ERR           <= 1'b0;
    end else begin
      DMA_ON <= 1'b0;
      DONE   <= 1'b0;

      if (state_reg != S_IDLE) begin
        credits_reg   <= credits_next;
        COMPLETED_CNT <= comp_overrun ? ISSUED_CNT : comp;
        if (comp_overrun) begin
          ERR <= 1'b1;
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (CFG_START) begin
            base_reg      <= CFG_BASE_ADR;
            buf_size_reg  <= CFG_BUF_SIZE;
            alloc_reg     <= CFG_ALLOC_SIZE;
            buf_cnt_reg   <= CFG_BUF_CNT;
            step_reg      <= (ADR_W+4)'(CFG_STRIDE) * (ADR_W+4)'(CFG_BUF_SIZE);
            baseline_reg  <= DMA_STATUS_CNT;
            offset_reg    <= '0;
            ISSUED_CNT    <= '0;
            COMPLETED_CNT <= '0;
            ERR           <= 1'b0;
            credits_reg   <= FIFO_CREDITS;
            BUSY          <= 1'b1;
            state_reg     <= S_ARM;
          end
        end
        S_ARM: begin
          if (run_end) begin
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (run_end) begin
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state_reg <= S_IDLE;
          end else if (issue_go) begin
            DMA_ON       <= 1'b1;
            DMA_ADR      <= base_reg + offset_reg;
            DMA_BUF_SIZE <= buf_size_reg;
            ISSUED_CNT   <= ISSUED_CNT + 16'd1;
            offset_reg   <= (offset_sum >= {4'd0, alloc_reg}) ? '0 : offset_sum[ADR_W-1:0];
            state_reg    <= S_GAP;
          end
        end
        S_GAP: begin
          if (run_end) begin
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_ISSUE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
